imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side counterpart of the pipeline CPU's byte-addressed instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and writes each one to a byte-wide instruction RAM port as 4 little-endian byte writes: byte 0 = bits [7:0] at addr+0, up to byte 3 = bits [31:24] at addr+3.
- Holds the CPU off the instruction memory while loading, then reports completion or error.

Parameters:
- BYTE_W, 8, memory byte width.
- INSTR_W, 32, instruction word width.
- ROM_DEPTH, 256, instruction memory size in bytes (64 instructions).
- CNT_W, 7, width of the word-count field; must hold ROM_DEPTH/4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle load request; sampled only in IDLE.
- base_addr  in  32  byte address of the first word; sampled with start.
- word_count  in  CNT_W  number of words to load; sampled with start.
- in_valid  in  1  instruction word valid.
- in_data  in  INSTR_W  instruction word.
- in_ready  out  1  loader can accept a word.
- mem_we  out  1  byte write enable.
- mem_addr  out  32  byte address.
- mem_wdata  out  BYTE_W  write byte.
- mem_rdata  in  BYTE_W  combinational read byte at mem_addr (readback only).
- cpu_hold  out  1  high while busy; the CPU deasserts its instruction-memory chip select.
- done  out  1  one-cycle pulse when the load completes.
- err_range  out  1  one-cycle pulse when a request is rejected.
- err_mismatch  out  1  sticky readback error; cleared on the next accepted start.

Behaviour:
- Reset:
  - All outputs are 0. The FSM goes to IDLE.
  - Address register, byte index and word counter are 0.
  - Reset mid-load aborts immediately: no further writes, and no done pulse.
- States: IDLE, LOAD, WRITE, VERIFY (macro only), DONE.
- IDLE:
  - A start with base_addr[1:0] != 0, or with base_addr + 4*word_count > ROM_DEPTH, pulses err_range the next cycle and stays in IDLE. The range check uses 33-bit arithmetic so there is no wrap-around.
  - A start with word_count == 0 goes to DONE.
  - Otherwise the loader latches addr = base_addr and remaining = word_count, then goes to LOAD.
  - cpu_hold = 1 in every state except IDLE.
- LOAD:
  - in_ready = 1.
  - On in_valid && in_ready, latch in_data, clear the byte index, and go to WRITE.
  - in_valid low simply waits; there is no timeout.
- WRITE:
  - Lasts 4 cycles with mem_we = 1, mem_addr = addr + idx, mem_wdata = word[8*idx +: 8], idx = 0..3.
  - After idx 3: addr += 4 and remaining -= 1.
  - Next state is VERIFY if the macro is enabled; otherwise LOAD if remaining != 0, else DONE.
  - in_ready = 0.
- DONE: done = 1 for exactly one cycle, then IDLE. cpu_hold drops in the same cycle as IDLE is entered.
- start asserted while not in IDLE is ignored; no error is raised.
- Latency without the macro: first handshake is possible 1 cycle after start; each word takes 5 cycles (1 handshake + 4 writes); done arrives 1 cycle after the last write.

Optional Feature:
- Macro: IMEM_LOAD_READBACK_EN.
- Defined:
  - VERIFY state lasts 4 cycles with mem_we = 0 and mem_addr = word_addr + idx.
  - mem_rdata is compared against the latched byte in the same cycle.
  - Any mismatch sets err_mismatch, which stays set until the next accepted start. The load continues regardless.
  - Each word then costs 9 cycles.
- Undefined: no VERIFY state, mem_rdata is ignored, and err_mismatch is tied to 0.

Decomposition:
- Shared package holds:
  - the FSM state encoding localparams (IDLE/LOAD/WRITE/VERIFY/DONE);
  - BYTE_W, INSTR_W and ROM_DEPTH constants, shared with the instruction memory;
  - a BYTES_PER_WORD = 4 constant.
- One sub-module is natural: imem_byte_lane_sel, a combinational word-to-byte selector that maps idx to word[8*idx +: 8]. It is reused by the write and verify paths.

Test Plan:
- Load 3 words at base 0x00 with in_valid held high: 0x20010008, 0x3402000c, 0x00221820.
  - Handshakes occur at cycles 1, 6 and 11 after start.
  - Writes are 08,00,01,20 at 0x00–0x03; 0c,00,02,34 at 0x04–0x07; 20,18,22,00 at 0x08–0x0b.
  - done pulses at cycle 16; cpu_hold is high for cycles 1–16.
- Range errors:
  - start with base 0x02 → err_range pulse, no mem_we, cpu_hold stays 0.
  - start with base 0xF8, count 3 → err_range pulse.
  - start with base 0xF0, count 4 → accepted; last write at 0xFF.
- Zero count and ignored start:
  - start with count 0 → done 2 cycles after start, no writes.
  - start asserted during WRITE → ignored, and the sequence is unchanged.
- Backpressure: in_valid low for 5 cycles in LOAD → in_ready stays high, no writes occur, and the load resumes with correct addresses.
- Reset mid-load: rst_n low during byte 2 of word 1 → outputs 0 asynchronously. A following load at base 0x10 writes correctly from 0x10.
- IMEM_LOAD_READBACK_EN:
  - Memory model corrupts byte 0x05 → err_mismatch sets in the VERIFY cycle for 0x05 and stays set through done.
  - The next accepted start clears it.
  - Each word takes 9 cycles.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader and the
// byte-addressed instruction memory it fills.
package imem_loader_pkg;

   localparam int BYTE_W         = 8;
   localparam int INSTR_W        = 32;
   localparam int ROM_DEPTH      = 256;
   localparam int BYTES_PER_WORD = 4;
   localparam int CNT_W          = 7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_WRITE  = 3'd2,
      ST_VERIFY = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Request, instruction stream, byte-wide memory port and status of the loader.
// master = the loader itself, slave = host / memory side.
interface imem_loader_if #(
   parameter int BYTE_W  = imem_loader_pkg::BYTE_W,
   parameter int INSTR_W = imem_loader_pkg::INSTR_W,
   parameter int CNT_W   = imem_loader_pkg::CNT_W
);
   import imem_loader_pkg::*;

   logic               start;
   logic [31:0]        base_addr;
   logic [CNT_W-1:0]   word_count;
   logic               in_valid;
   logic [INSTR_W-1:0] in_data;
   logic               in_ready;
   logic               mem_we;
   logic [31:0]        mem_addr;
   logic [BYTE_W-1:0]  mem_wdata;
   logic [BYTE_W-1:0]  mem_rdata;
   logic               cpu_hold;
   logic               done;
   logic               err_range;
   logic               err_mismatch;

   modport master (
      input  start, base_addr, word_count, in_valid, in_data, mem_rdata,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done,
             err_range, err_mismatch
   );

   modport slave (
      output start, base_addr, word_count, in_valid, in_data, mem_rdata,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done,
             err_range, err_mismatch
   );

endinterface

// File: rtl/imem_byte_lane_sel.sv
// Little-endian word-to-byte selector: lane = word[BYTE_W*idx +: BYTE_W].
module imem_byte_lane_sel #(
   parameter int BYTE_W  = imem_loader_pkg::BYTE_W,
   parameter int INSTR_W = imem_loader_pkg::INSTR_W,
   parameter int IDX_W   = $clog2(imem_loader_pkg::BYTES_PER_WORD)
) (
   input  logic [INSTR_W-1:0] word,
   input  logic [IDX_W-1:0]   idx,
   output logic [BYTE_W-1:0]  lane
);
   import imem_loader_pkg::*;

   assign lane = word[int'(idx) * BYTE_W +: BYTE_W];

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction RAM while holding the CPU off.
// Optional readback verification: define IMEM_LOAD_READBACK_EN.
module imem_loader #(
   parameter int BYTE_W    = imem_loader_pkg::BYTE_W,
   parameter int INSTR_W   = imem_loader_pkg::INSTR_W,
   parameter int ROM_DEPTH = imem_loader_pkg::ROM_DEPTH,
   parameter int CNT_W     = imem_loader_pkg::CNT_W
) (
   input logic           clk,
   input logic           rst_n,
   imem_loader_if.master bus
);
   import imem_loader_pkg::*;

   localparam int IDX_W = $clog2(BYTES_PER_WORD);

   state_t             state_q;
   logic [31:0]        addr_q;
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   remaining_q;
   logic [INSTR_W-1:0] word_q;
   logic               in_ready_q;
   logic               mem_we_q;
   logic [31:0]        mem_addr_q;
   logic [BYTE_W-1:0]  mem_wdata_q;
   logic               cpu_hold_q;
   logic               done_q;
   logic               err_range_q;

   logic [INSTR_W-1:0] wr_word;
   logic [IDX_W-1:0]   wr_idx;
   logic [BYTE_W-1:0]  wr_byte;
   logic               last_idx;

   // 33-bit end address so a base near 4 GiB cannot wrap back into range.
   function automatic logic range_bad(input logic [31:0] base, input logic [CNT_W-1:0] cnt);
      logic [32:0] end_addr;
      end_addr = {1'b0, base} + {{(33-CNT_W-2){1'b0}}, cnt, 2'b00};
      return (base[1:0] != 2'b00) || (end_addr > 33'(ROM_DEPTH));
   endfunction

   // Outputs are registered, so the write lane looks one byte ahead.
   always_comb begin
      wr_word  = (state_q == ST_LOAD) ? bus.in_data : word_q;
      wr_idx   = (state_q == ST_LOAD) ? '0 : idx_q + IDX_W'(1);
      last_idx = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
   end

   imem_byte_lane_sel #(.BYTE_W(BYTE_W), .INSTR_W(INSTR_W), .IDX_W(IDX_W)) u_wr_lane (
      .word (wr_word),
      .idx  (wr_idx),
      .lane (wr_byte)
   );

`ifdef IMEM_LOAD_READBACK_EN
   logic [BYTE_W-1:0] vf_byte;
   logic              err_mismatch_q;

   imem_byte_lane_sel #(.BYTE_W(BYTE_W), .INSTR_W(INSTR_W), .IDX_W(IDX_W)) u_vf_lane (
      .word (word_q),
      .idx  (idx_q),
      .lane (vf_byte)
   );
`endif

   always_ff @(posedge clk) begin
      if (state_q == ST_LOAD && bus.in_valid && in_ready_q)
         word_q <= bus.in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         idx_q       <= '0;
         remaining_q <= '0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b0;
         done_q      <= 1'b0;
         err_range_q <= 1'b0;
`ifdef IMEM_LOAD_READBACK_EN
         err_mismatch_q <= 1'b0;
`endif
      end else begin
         done_q      <= 1'b0;
         err_range_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (range_bad(bus.base_addr, bus.word_count)) begin
                     err_range_q <= 1'b1;
                  end else begin
`ifdef IMEM_LOAD_READBACK_EN
                     err_mismatch_q <= 1'b0;
`endif
                     addr_q      <= bus.base_addr;
                     remaining_q <= bus.word_count;
                     cpu_hold_q  <= 1'b1;
                     if (bus.word_count == '0) begin
                        state_q <= ST_DONE;
                     end else begin
                        state_q    <= ST_LOAD;
                        in_ready_q <= 1'b1;
                     end
                  end
               end
            end
            ST_LOAD: begin
               if (bus.in_valid && in_ready_q) begin
                  in_ready_q  <= 1'b0;
                  idx_q       <= '0;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr_q;
                  mem_wdata_q <= wr_byte;
                  state_q     <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (!last_idx) begin
                  idx_q       <= idx_q + IDX_W'(1);
                  mem_addr_q  <= mem_addr_q + 32'd1;
                  mem_wdata_q <= wr_byte;
               end else begin
                  mem_we_q    <= 1'b0;
                  idx_q       <= '0;
                  addr_q      <= addr_q + 32'(BYTES_PER_WORD);
                  remaining_q <= remaining_q - CNT_W'(1);
`ifdef IMEM_LOAD_READBACK_EN
                  mem_addr_q  <= addr_q;
                  state_q     <= ST_VERIFY;
`else
                  if (remaining_q != CNT_W'(1)) begin
                     state_q    <= ST_LOAD;
                     in_ready_q <= 1'b1;
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
`endif
               end
            end
`ifdef IMEM_LOAD_READBACK_EN
            ST_VERIFY: begin
               // mem_rdata is combinational at mem_addr, so it lines up with idx_q.
               if (bus.mem_rdata != vf_byte)
                  err_mismatch_q <= 1'b1;
               if (!last_idx) begin
                  idx_q      <= idx_q + IDX_W'(1);
                  mem_addr_q <= mem_addr_q + 32'd1;
               end else begin
                  idx_q <= '0;
                  if (remaining_q != '0) begin
                     state_q    <= ST_LOAD;
                     in_ready_q <= 1'b1;
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
`endif
            ST_DONE: begin
               // A zero-length request arrives here without done set and pulses one cycle later.
               if (done_q) begin
                  state_q    <= ST_IDLE;
                  cpu_hold_q <= 1'b0;
               end else begin
                  done_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.cpu_hold  = cpu_hold_q;
   assign bus.done      = done_q;
   assign bus.err_range = err_range_q;
`ifdef IMEM_LOAD_READBACK_EN
   assign bus.err_mismatch = err_mismatch_q;
`else
   assign bus.err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-wide memory model with write log, cycle-exact load checks.
module tb_imem_loader;

`ifdef IMEM_LOAD_READBACK_EN
   localparam int WORD_CYC = 9;
   localparam int MIS_EXP  = 1;
`else
   localparam int WORD_CYC = 5;
   localparam int MIS_EXP  = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_fail = 0;

   logic [7:0]  mem [0:255];
   logic [31:0] log_addr [0:127];
   logic [7:0]  log_data [0:127];
   int          wr_n = 0;
   logic [31:0] wq [0:3];

   imem_loader_if bus ();

   imem_loader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_we) begin
         mem[bus.mem_addr[7:0]]  <= bus.mem_wdata;
         log_addr[wr_n & 127]    <= bus.mem_addr;
         log_data[wr_n & 127]    <= bus.mem_wdata;
         wr_n                    <= wr_n + 1;
      end
   end

   // Byte 0x05 reads back corrupted; only a readback-enabled build looks at it.
   assign bus.mem_rdata = (bus.mem_addr == 32'h5) ? ~mem[5] : mem[bus.mem_addr[7:0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_load(input logic [31:0] base, input logic [6:0] cnt, input int stall_word,
                           input int stall_len, input int ign_cyc, output int done_cyc,
                           output bit err_seen);
      int k;
      int stall;
      bit hs;
      k = 0; stall = 0; hs = 0; done_cyc = -1; err_seen = 0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.base_addr = base; bus.word_count = cnt;
      bus.in_valid = 1'b1; bus.in_data = wq[0];
      for (int c = 1; c <= 80 && done_cyc < 0; c++) begin
         @(posedge clk); #1;
         bus.start = (c == ign_cyc);
         if (c == ign_cyc) begin
            bus.base_addr = 32'h80; bus.word_count = 7'd1;
         end
         if (hs) begin
            k++;
            bus.in_data = wq[k & 3];
            if (k == stall_word) stall = stall_len;
         end
         bus.in_valid = (stall == 0);
         @(negedge clk);
         hs = bus.in_valid && bus.in_ready;
         if (stall > 0 && bus.in_ready) begin
            chk("bp_no_write", bus.mem_we, 0);
            stall--;
         end
         if (bus.err_range) err_seen = 1;
         if (bus.done) done_cyc = c;
      end
      bus.start = 1'b0;
   endtask

   task automatic check_writes(input logic [31:0] base, input int cnt, input int n0);
      logic [31:0] w;
      chk("wr_count", wr_n - n0, 4 * cnt);
      for (int i = 0; i < 4 * cnt && i < wr_n - n0; i++) begin
         w = wq[i / 4];
         chk("wr_addr", log_addr[(n0 + i) & 127], base + i);
         chk("wr_data", 32'(log_data[(n0 + i) & 127]), 32'(w[8 * (i % 4) +: 8]));
      end
   endtask

   task automatic range_req(input logic [31:0] base, input logic [6:0] cnt);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.base_addr = base; bus.word_count = cnt;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("rng_err_pulse", bus.err_range, 1);
      chk("rng_hold", bus.cpu_hold, 0);
      chk("rng_we", bus.mem_we, 0);
      chk("rng_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("rng_err_clear", bus.err_range, 0);
      chk("rng_hold2", bus.cpu_hold, 0);
   endtask

   initial begin
      logic [7:0] t1_bytes [0:11];
      int  j, ph, dc, n0;
      bit  wr, es, found;

      t1_bytes = '{8'h08, 8'h00, 8'h01, 8'h20, 8'h0c, 8'h00, 8'h02, 8'h34,
                   8'h20, 8'h18, 8'h22, 8'h00};
      bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
      bus.in_valid = 1'b0; bus.in_data = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
      chk("rst_cpu_hold", bus.cpu_hold, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err_range", bus.err_range, 0);
      chk("rst_err_mismatch", bus.err_mismatch, 0);
      rst_n = 1'b1;

      // three words at base 0, in_valid held high, cycle-exact
      wq = '{32'h20010008, 32'h3402000c, 32'h00221820, 32'h0};
      @(posedge clk); #1;
      bus.start = 1'b1; bus.base_addr = 32'h0; bus.word_count = 7'd3;
      bus.in_valid = 1'b1; bus.in_data = wq[0];
      j = 0;
      for (int c = 1; c <= 2 + 3 * WORD_CYC; c++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.in_data = wq[((c - 1) / WORD_CYC) & 3];
         @(negedge clk);
         ph = (c - 1) % WORD_CYC;
         wr = (c < 1 + 3 * WORD_CYC) && ph >= 1 && ph <= 4;
         chk("t1_cpu_hold", bus.cpu_hold, 32'(c <= 1 + 3 * WORD_CYC));
         chk("t1_in_ready", bus.in_ready, 32'((c < 1 + 3 * WORD_CYC) && ph == 0));
         chk("t1_done", bus.done, 32'(c == 1 + 3 * WORD_CYC));
         chk("t1_mem_we", bus.mem_we, 32'(wr));
         if (wr && j < 12) begin
            chk("t1_mem_addr", bus.mem_addr, j);
            chk("t1_mem_wdata", 32'(bus.mem_wdata), 32'(t1_bytes[j]));
            j++;
         end
      end
      chk("t1_write_total", j, 12);
      chk("t1_err_mismatch", bus.err_mismatch, MIS_EXP);
      bus.in_valid = 1'b0;

      // zero count: done two cycles after start, no writes, mismatch flag cleared
      n0 = wr_n;
      run_load(32'h40, 7'd0, -1, 0, -1, dc, es);
      chk("zc_done_cyc", dc, 2);
      chk("zc_writes", wr_n - n0, 0);
      chk("zc_err_mismatch", bus.err_mismatch, 0);
      @(negedge clk);
      chk("zc_hold_after", bus.cpu_hold, 0);

      // range errors
      bus.in_valid = 1'b0;
      n0 = wr_n;
      range_req(32'h02, 7'd1);
      range_req(32'hF8, 7'd3);
      chk("rng_no_writes", wr_n - n0, 0);

      // exactly-fits load ending at 0xFF
      wq = '{32'h11223344, 32'h55667788, 32'h99aabbcc, 32'hddeeff00};
      n0 = wr_n;
      run_load(32'hF0, 7'd4, -1, 0, -1, dc, es);
      chk("f0_done_cyc", dc, 1 + 4 * WORD_CYC);
      check_writes(32'hF0, 4, n0);
      chk("f0_last_addr", log_addr[(n0 + 15) & 127], 32'hFF);
      chk("f0_last_data", 32'(log_data[(n0 + 15) & 127]), 32'hdd);
      chk("f0_first_mem", 32'(mem[8'hF0]), 32'h44);

      // backpressure: in_valid low for 5 LOAD cycles before word 1
      wq = '{32'hcafef00d, 32'h0badbeef, 32'h0, 32'h0};
      n0 = wr_n;
      run_load(32'h20, 7'd2, 1, 5, -1, dc, es);
      chk("bp_done_cyc", dc, 1 + 2 * WORD_CYC + 5);
      check_writes(32'h20, 2, n0);
      chk("bp_word1_byte0", 32'(mem[8'h24]), 32'hef);
      chk("bp_word1_byte3", 32'(mem[8'h27]), 32'h0b);

      // start during WRITE is ignored
      wq = '{32'h01234567, 32'h89abcdef, 32'h0, 32'h0};
      n0 = wr_n;
      run_load(32'h30, 7'd2, -1, 0, 3, dc, es);
      chk("ign_done_cyc", dc, 1 + 2 * WORD_CYC);
      chk("ign_no_err", es, 0);
      check_writes(32'h30, 2, n0);
      @(negedge clk);
      chk("ign_back_idle", bus.cpu_hold, 0);

      // reset in the middle of byte 2 of word 1
      wq = '{32'h44332211, 32'h88776655, 32'h0, 32'h0};
      found = 0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.base_addr = 32'h0; bus.word_count = 7'd2;
      bus.in_valid = 1'b1; bus.in_data = wq[0];
      for (int c = 1; c <= 40 && !found; c++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.in_data = wq[((c - 1) / WORD_CYC) & 3];
         @(negedge clk);
         if (bus.mem_we && bus.mem_addr == 32'h6) found = 1;
      end
      chk("mid_rst_reached", found, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_mem_we", bus.mem_we, 0);
      chk("mid_rst_cpu_hold", bus.cpu_hold, 0);
      chk("mid_rst_in_ready", bus.in_ready, 0);
      chk("mid_rst_mem_addr", bus.mem_addr, 0);
      chk("mid_rst_done", bus.done, 0);
      n0 = wr_n;
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_no_writes", wr_n - n0, 0);
      chk("mid_rst_done2", bus.done, 0);
      rst_n = 1'b1;

      wq = '{32'ha1b2c3d4, 32'h0, 32'h0, 32'h0};
      n0 = wr_n;
      run_load(32'h10, 7'd1, -1, 0, -1, dc, es);
      chk("post_rst_done_cyc", dc, 1 + WORD_CYC);
      check_writes(32'h10, 1, n0);
      chk("post_rst_byte0", 32'(mem[8'h10]), 32'hd4);
      chk("post_rst_byte3", 32'(mem[8'h13]), 32'ha1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
